test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameters: FRAMES_PER_PATTERN, default 120, auto-advance period in frames; BAR_WIDTH, default 80, colour-bar width in pixels; CHECK_SHIFT, default 5, log2 checker square size; SCROLL_STEP, default 2, checker scroll in pixels per frame.
REQ-002 SHALL have ports:
- clk_pixel  in  1  pixel clock; one clock; every register on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cx, cy  in  10 each  current pixel coordinate, from the hdmi core
- screen_start_x, screen_start_y  in  10 each  first active column and row
- frame_width, frame_height  in  10 each  total frame size including blanking
- auto_en  in  1  enables automatic pattern cycling
- next_pattern  in  1  single-cycle pulse that advances the pattern
- rgb  out  24  {R,G,B} 8 bits each, registered, to hdmi rgb
- pattern_id  out  2  current pattern
- frame_tick  out  1  one-cycle pulse at the last pixel of a frame

Function
REQ-003 SHALL drive rgb with exactly 1 cycle latency from the cx/cy it corresponds to.
REQ-004 SHALL compute x_rel = cx - screen_start_x and y_rel = cy - screen_start_y, 10-bit modulo.
REQ-005 SHALL output rgb = 0 when cx < screen_start_x or cy < screen_start_y (blanking).
REQ-006 SHALL assert frame_tick for one cycle when cx == frame_width-1 and cy == frame_height-1; it is registered, so it is high in the cycle after that coordinate is presented.
REQ-007 SHALL encode the pattern state machine as: BORDER(0), BARS(1), CHECKER(2), GRADIENT(3); advancing goes 0->1->2->3->0.
REQ-008 SHALL advance the pattern on the cycle after next_pattern is high, regardless of auto_en.
REQ-009 SHALL keep a frame counter while auto_en=1: on frame_tick with count == FRAMES_PER_PATTERN-1, advance the pattern and clear the count; otherwise increment the count.
REQ-010 SHALL, if next_pattern and an auto advance occur in the same cycle, advance by exactly one pattern and clear the frame counter.
REQ-011 SHALL clear the frame counter and freeze it while auto_en=0.
REQ-012 SHALL clear the frame counter on any manual advance.
REQ-013 SHALL, in BORDER, set R=FF where cx==screen_start_x, G=FF where cy==screen_start_y, and B=FF where cx==frame_width-1 or cy==frame_height-1; other channels are 0.
REQ-014 SHALL, in BARS, use a bar counter (0..7) and a pixel counter:
- both reset at cx==screen_start_x
- the bar counter increments after BAR_WIDTH pixels and saturates at 7
- colour = {bar[2]?FF:00, bar[1]?FF:00, bar[0]?FF:00}, so bar 0 is black and bar 7 is white
REQ-015 SHALL, in CHECKER, output white (FFFFFF) when bit CHECK_SHIFT of (x_rel+scroll) XOR bit CHECK_SHIFT of y_rel is 1, else black.
REQ-016 SHALL keep scroll as a 10-bit register that adds SCROLL_STEP on each frame_tick, wrapping mod 1024, and that runs in all patterns.
REQ-017 SHALL, in GRADIENT, output R=G=B=x_rel[9:2].
REQ-018 SHALL let a pattern change take effect only at pixel boundaries; a mid-frame change switches pattern on the next pixel, with no glitch state.

Reset
REQ-019 SHALL, while rst_n=0, hold:
- rgb = 0
- pattern_id = BORDER
- frame_tick = 0
- frame counter = 0, scroll = 0, bar and pixel counters = 0
REQ-020 SHALL apply reset asynchronously on assertion and release it synchronously; the first valid rgb is the cycle after the first clk_pixel edge with rst_n=1.
REQ-021 SHALL, if reset is asserted mid-frame, force black output immediately, and SHALL resume at the BORDER pattern from the current cx/cy.

Structure
REQ-022 SHALL place the pattern enum (pattern_t) and the 8-bit colour constants (COL_FULL, COL_ZERO) in a shared package, hdmi_pattern_pkg.
REQ-023 SHALL use one sub-module, pattern_sequencer, that holds the pattern FSM, frame counter and frame_tick; the pixel datapath stays in test_pattern_gen.

Verification
REQ-024 SHALL cover these directed scenarios, with 640x480 timing (frame 800x525, screen start 160,45):
- Reset: rst_n low mid-frame -> rgb=0 and pattern_id=0 within the same cycle; after release, the border pixel at cx=160 gives rgb=FF0000 one cycle later.
- BARS: cx=160+80*k+5, cy=100 -> rgb bits match k (k=3 -> 00FFFF; k=7 -> FFFFFF); cx=100 -> 000000.
- Auto cycle: auto_en=1, FRAMES_PER_PATTERN=2 -> pattern_id goes 0,0,1,1,2,2,3,3,0 across frame_ticks; auto_en=0 -> it holds.
- Simultaneous events: next_pattern in the frame_tick cycle at count==FRAMES_PER_PATTERN-1 -> advances by one only, and the counter reads 0.
- CHECKER scroll: after 16 frame_ticks, scroll=32 -> pixel x_rel=0, y_rel=0 is white; after 512 frame_ticks, scroll wraps to 0.
- GRADIENT: x_rel=0 -> 000000; x_rel=639 -> 9F9F9F; latency is exactly 1 cycle.

Source files
------------

// File: rtl/hdmi_pattern_pkg.sv
// rtl/hdmi_pattern_pkg.sv - shared pattern encoding and colour constants for the test pattern generator
package hdmi_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BORDER   = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_t;

  localparam logic [7:0] COL_FULL = 8'hFF;
  localparam logic [7:0] COL_ZERO = 8'h00;

  function automatic logic [7:0] col_sel(input logic on);
    return on ? COL_FULL : COL_ZERO;
  endfunction

endpackage

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - pattern FSM, auto-advance frame counter and frame tick
module pattern_sequencer
  import hdmi_pattern_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [9:0] cx_i,
  input  logic [9:0] cy_i,
  input  logic [9:0] frame_width_i,
  input  logic [9:0] frame_height_i,
  input  logic       auto_en_i,
  input  logic       next_pattern_i,
  output pattern_t   pattern_o,
  output logic       frame_tick_o
);

  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);

  pattern_t         pattern_q, pattern_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             auto_adv;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= PAT_BORDER;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
    end
  end

  // A manual pulse coinciding with an auto advance still moves one step only.
  always_comb begin
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    tick_d    = (cx_i == frame_width_i - 10'd1) && (cy_i == frame_height_i - 10'd1);
    auto_adv  = auto_en_i && tick_q && (cnt_q == CNT_LAST);

    if (!auto_en_i) begin
      cnt_d = '0;
    end else if (tick_q) begin
      cnt_d = auto_adv ? '0 : cnt_q + 1'b1;
    end

    if (next_pattern_i || auto_adv) begin
      cnt_d = '0;
      case (pattern_q)
        PAT_BORDER:  pattern_d = PAT_BARS;
        PAT_BARS:    pattern_d = PAT_CHECKER;
        PAT_CHECKER: pattern_d = PAT_GRADIENT;
        default:     pattern_d = PAT_BORDER;
      endcase
    end
  end

  assign pattern_o    = pattern_q;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - HDMI test pattern generator: border, colour bars, scrolling checker, gradient
module test_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BAR_WIDTH          = 80,
  parameter int CHECK_SHIFT        = 5,
  parameter int SCROLL_STEP        = 2
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic [9:0]  screen_start_x,
  input  logic [9:0]  screen_start_y,
  input  logic [9:0]  frame_width,
  input  logic [9:0]  frame_height,
  input  logic        auto_en,
  input  logic        next_pattern,
  output logic [23:0] rgb,
  output logic [1:0]  pattern_id,
  output logic        frame_tick
);

  localparam logic [9:0] BAR_LAST   = 10'(BAR_WIDTH - 1);
  localparam logic [9:0] SCROLL_INC = 10'(SCROLL_STEP);

  pattern_t    pattern;
  logic        tick;
  logic [9:0]  x_rel, y_rel, x_scr;
  logic        in_blank;
  logic [2:0]  bar_q, bar_d, bar_cur;
  logic [9:0]  pix_q, pix_d, pix_cur;
  logic [9:0]  scroll_q, scroll_d;
  logic [23:0] rgb_q, rgb_d;

  pattern_sequencer #(
    .FRAMES_PER_PATTERN(FRAMES_PER_PATTERN)
  ) u_seq (
    .clk_pixel     (clk_pixel),
    .rst_n         (rst_n),
    .cx_i          (cx),
    .cy_i          (cy),
    .frame_width_i (frame_width),
    .frame_height_i(frame_height),
    .auto_en_i     (auto_en),
    .next_pattern_i(next_pattern),
    .pattern_o     (pattern),
    .frame_tick_o  (tick)
  );

  assign x_rel    = cx - screen_start_x;
  assign y_rel    = cy - screen_start_y;
  assign x_scr    = x_rel + scroll_q;
  assign in_blank = (cx < screen_start_x) || (cy < screen_start_y);

  // Bar position restarts on the first active column, so the colour for this pixel uses the restarted value.
  always_comb begin
    bar_cur = bar_q;
    pix_cur = pix_q;
    if (cx == screen_start_x) begin
      bar_cur = '0;
      pix_cur = '0;
    end
    bar_d = bar_cur;
    pix_d = pix_cur + 10'd1;
    if (pix_cur == BAR_LAST) begin
      pix_d = '0;
      if (bar_cur != 3'd7) begin
        bar_d = bar_cur + 3'd1;
      end
    end
  end

  assign scroll_d = tick ? scroll_q + SCROLL_INC : scroll_q;

  always_comb begin
    rgb_d = {COL_ZERO, COL_ZERO, COL_ZERO};
    if (!in_blank) begin
      case (pattern)
        PAT_BORDER: rgb_d = {col_sel(cx == screen_start_x),
                             col_sel(cy == screen_start_y),
                             col_sel((cx == frame_width - 10'd1) || (cy == frame_height - 10'd1))};
        PAT_BARS:    rgb_d = {col_sel(bar_cur[2]), col_sel(bar_cur[1]), col_sel(bar_cur[0])};
        PAT_CHECKER: rgb_d = {3{col_sel((((x_scr ^ y_rel) >> CHECK_SHIFT) & 10'd1) != 10'd0)}};
        default:     rgb_d = {3{x_rel[9:2]}};
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      bar_q    <= '0;
      pix_q    <= '0;
      scroll_q <= '0;
      rgb_q    <= '0;
    end else begin
      bar_q    <= bar_d;
      pix_q    <= pix_d;
      scroll_q <= scroll_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb        = rgb_q;
  assign pattern_id = pattern;
  assign frame_tick = tick;

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb/tb_test_pattern_gen.sv - self-checking bench for test_pattern_gen against a behavioural model
module tb_test_pattern_gen;

  localparam int FPP = 2;
  localparam int FW  = 800;
  localparam int FH  = 525;
  localparam int SX  = 160;
  localparam int SY  = 45;

  logic        clk_pixel = 1'b0;
  logic        rst_n;
  logic [9:0]  cx, cy;
  logic [9:0]  ssx, ssy, fw, fh;
  logic        auto_en, next_pattern;
  logic [23:0] rgb;
  logic [1:0]  pattern_id;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int m_pat, m_cnt, m_scroll;
  bit m_tick;
  bit bars_ok;
  int auto_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  always #5 clk_pixel = ~clk_pixel;

  test_pattern_gen #(
    .FRAMES_PER_PATTERN(FPP),
    .BAR_WIDTH         (80),
    .CHECK_SHIFT       (5),
    .SCROLL_STEP       (2)
  ) dut (
    .clk_pixel     (clk_pixel),
    .rst_n         (rst_n),
    .cx            (cx),
    .cy            (cy),
    .screen_start_x(ssx),
    .screen_start_y(ssy),
    .frame_width   (fw),
    .frame_height  (fh),
    .auto_en       (auto_en),
    .next_pattern  (next_pattern),
    .rgb           (rgb),
    .pattern_id    (pattern_id),
    .frame_tick    (frame_tick)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_pixel(input int pat, input int x, input int y, input int scroll);
    int xr, yr, k, g;
    if (x < SX || y < SY) return 24'h0;
    xr = x - SX;
    yr = y - SY;
    case (pat)
      0: return {(x == SX) ? 8'hFF : 8'h00, (y == SY) ? 8'hFF : 8'h00,
                 (x == FW - 1 || y == FH - 1) ? 8'hFF : 8'h00};
      1: begin
        k = xr / 80;
        if (k > 7) k = 7;
        return {(k >= 4) ? 8'hFF : 8'h00, ((k / 2) % 2 == 1) ? 8'hFF : 8'h00, (k % 2 == 1) ? 8'hFF : 8'h00};
      end
      2: return (((((xr + scroll) % 1024) / 32) % 2) != ((yr / 32) % 2)) ? 24'hFFFFFF : 24'h0;
      default: begin
        g = xr / 4;
        return {g[7:0], g[7:0], g[7:0]};
      end
    endcase
  endfunction

  function automatic int rand_x();
    return int'($urandom_range(0, FW - 1));
  endfunction

  function automatic int rand_y();
    return int'($urandom_range(0, FH - 2));
  endfunction

  function automatic int act_x();
    return SX + int'($urandom_range(0, 638));
  endfunction

  function automatic int act_y();
    return SY + int'($urandom_range(0, 478));
  endfunction

  // One pixel clock: present (x,y), advance the model, then compare after the edge.
  task automatic step(input int x, input int y, input bit np, input bit chk_rgb);
    logic [23:0] e_rgb;
    bit          adv, do_rgb;
    cx           = 10'(x);
    cy           = 10'(y);
    next_pattern = np;
    e_rgb  = model_pixel(m_pat, x, y, m_scroll);
    do_rgb = chk_rgb && (m_pat != 1 || bars_ok);
    adv    = np || (auto_en && m_tick && m_cnt == FPP - 1);
    if (!auto_en || adv) m_cnt = 0;
    else if (m_tick) m_cnt++;
    if (m_tick) m_scroll = (m_scroll + 2) % 1024;
    if (adv) m_pat = (m_pat + 1) % 4;
    m_tick = (x == FW - 1 && y == FH - 1);
    @(posedge clk_pixel);
    #1;
    next_pattern = 1'b0;
    if (do_rgb) check("rgb", rgb, e_rgb);
    check("pattern_id", 24'(pattern_id), 24'(m_pat));
    check("frame_tick", 24'(frame_tick), 24'(m_tick));
  endtask

  task automatic model_reset();
    m_pat    = 0;
    m_cnt    = 0;
    m_scroll = 0;
    m_tick   = 1'b0;
  endtask

  initial begin
    ssx = 10'(SX); ssy = 10'(SY); fw = 10'(FW); fh = 10'(FH);
    rst_n = 1'b0; cx = '0; cy = '0; auto_en = 1'b0; next_pattern = 1'b0;
    bars_ok = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_pixel);
    #1;
    check("reset_rgb", rgb, 24'h0);
    check("reset_pattern", 24'(pattern_id), 24'h0);
    check("reset_tick", 24'(frame_tick), 24'h0);

    rst_n = 1'b1;
    step(SX, 100, 1'b0, 1'b1);
    check("border_first", rgb, 24'hFF0000);

    for (int i = 0; i < 150; i++) step(rand_x(), rand_y(), 1'b0, 1'b1);
    step(SX, SY, 1'b0, 1'b1);
    check("border_corner", rgb, 24'hFFFF00);

    auto_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(FW - 1, FH - 1, 1'b0, 1'b1);
      check("auto_seq", 24'(pattern_id), 24'(auto_seq[i]));
      step(act_x(), act_y(), 1'b0, 1'b1);
    end
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(FW - 1, FH - 1, 1'b0, 1'b1);
      step(act_x(), act_y(), 1'b0, 1'b1);
      check("auto_hold", 24'(pattern_id), 24'h0);
    end

    auto_en = 1'b1;
    step(FW - 1, FH - 1, 1'b0, 1'b1);
    step(act_x(), act_y(), 1'b0, 1'b1);
    step(FW - 1, FH - 1, 1'b0, 1'b1);
    step(act_x(), act_y(), 1'b1, 1'b1);
    check("simul_adv", 24'(pattern_id), 24'h1);
    step(FW - 1, FH - 1, 1'b0, 1'b1);
    step(act_x(), act_y(), 1'b0, 1'b1);
    check("simul_cnt_cleared", 24'(pattern_id), 24'h1);
    step(FW - 1, FH - 1, 1'b0, 1'b1);
    step(act_x(), act_y(), 1'b0, 1'b1);
    check("simul_next_auto", 24'(pattern_id), 24'h2);
    auto_en = 1'b0;

    for (int i = 0; i < 150; i++) step(rand_x(), rand_y(), 1'b0, 1'b1);

    step(act_x(), act_y(), 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step(rand_x(), rand_y(), 1'b0, 1'b1);
    step(SX, 200, 1'b0, 1'b1);
    check("grad_x0", rgb, 24'h000000);
    step(FW - 1, 200, 1'b0, 1'b1);
    check("grad_x639", rgb, 24'h9F9F9F);
    step(SX, 201, 1'b0, 1'b1);
    check("grad_latency", rgb, 24'h000000);

    step(act_x(), act_y(), 1'b1, 1'b1);
    step(act_x(), act_y(), 1'b1, 1'b1);
    bars_ok = 1'b1;
    for (int x = 100; x <= 725; x++) begin
      step(x, 100, 1'b0, 1'b1);
      if (x == 100) check("bars_blank", rgb, 24'h000000);
      if (x == SX + 80 * 3 + 5) check("bars_k3", rgb, 24'h00FFFF);
      if (x == SX + 80 * 7 + 5) check("bars_k7", rgb, 24'hFFFFFF);
    end
    begin
      int y;
      y = act_y();
      for (int x = 150; x < FW; x++) step(x, y, 1'b0, 1'b1);
    end
    bars_ok = 1'b0;

    cx = 10'd300;
    cy = 10'd200;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rgb", rgb, 24'h0);
    check("rst_mid_pattern", 24'(pattern_id), 24'h0);
    check("rst_mid_tick", 24'(frame_tick), 24'h0);
    model_reset();
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    step(SX, 300, 1'b0, 1'b1);
    check("rst_resume_border", rgb, 24'hFF0000);

    step(act_x(), act_y(), 1'b1, 1'b1);
    step(act_x(), act_y(), 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(FW - 1, FH - 1, 1'b0, 1'b1);
      step(act_x(), act_y(), 1'b0, 1'b1);
    end
    step(SX, SY, 1'b0, 1'b1);
    check("scroll32_white", rgb, 24'hFFFFFF);
    for (int i = 0; i < 496; i++) begin
      step(FW - 1, FH - 1, 1'b0, 1'b1);
      step(act_x(), act_y(), 1'b0, 1'b1);
    end
    step(SX, SY, 1'b0, 1'b1);
    check("scroll_wrap_black", rgb, 24'h000000);
    step(SX + 32, SY, 1'b0, 1'b1);
    check("scroll_wrap_white", rgb, 24'hFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
